// File: rtl/mem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter
//  Description : Two-requester arbiter in front of a single-port synchronous
//                memory. A data port (loads/stores) normally wins over an
//                instruction-fetch port. A starvation counter forces the
//                fetch through once it has lost MAX_WAIT consecutive cycles.
//                Grants are combinational. The memory command issues in the
//                grant cycle. Read data returns exactly one cycle later and
//                is routed back by a small response FSM.
//                Misaligned data accesses are granted without touching memory.
//                They produce a one-cycle error response instead.
//
//  Ports
//    clk, rst_n                 clock, synchronous active-low reset
//    i_req/i_addr               fetch request and byte address
//    i_gnt/i_rvalid/i_rdata     fetch grant and read response
//    d_req/d_we/d_addr/d_wdata  data request (store when d_we=1)
//    d_gnt/d_rvalid/d_rdata     data grant and load response
//    d_err                      misaligned data access response flag
//    m_en/m_we/m_addr/m_wdata   memory command (word address)
//    m_rdata                    memory read data, valid cycle after read
//
//  Revision    : 1.0  initial release
// ============================================================================
module mem_arbiter #(
    parameter int ADDR_W   = 10,
    parameter int MAX_WAIT = 3
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              i_req,
    input  logic [31:0]       i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [31:0]       i_rdata,

    input  logic              d_req,
    input  logic              d_we,
    input  logic [31:0]       d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [31:0]       d_rdata,
    output logic              d_err,

    output logic              m_en,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [31:0]       m_wdata,
    input  logic [31:0]       m_rdata
);

    // Counter must be able to hold MAX_WAIT; keep at least one bit.
    localparam int c_CNT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [c_CNT_W-1:0] c_MAX_CNT = c_CNT_W'(MAX_WAIT);

    typedef enum logic [1:0] {
        RSP_NONE  = 2'd0,
        RSP_FETCH = 2'd1,
        RSP_LOAD  = 2'd2,
        RSP_ERR   = 2'd3
    } rspState_t;

    rspState_t            r_rspState;
    rspState_t            w_rspNext;
    logic [c_CNT_W-1:0]   r_starveCnt;

    logic                 w_fetchForced;
    logic                 w_iGnt;
    logic                 w_dGnt;
    logic                 w_dMisaligned;
    logic                 w_unusedAddrBits;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    assign w_fetchForced = i_req && (r_starveCnt == c_MAX_CNT);
    assign w_dMisaligned = (d_addr[1:0] != 2'b00);

    // Grants are gated by rst_n so nothing is accepted while reset is held.
    // Fetch wins only when data is idle or the fetch has waited long enough.
    assign w_iGnt = rst_n && i_req && (!d_req || w_fetchForced);
    assign w_dGnt = rst_n && d_req && !w_iGnt;

    assign i_gnt = w_iGnt;
    assign d_gnt = w_dGnt;

    // Upper address bits select nothing: the memory address wraps.
    // The fetch byte offset is never checked.
    assign w_unusedAddrBits = ^{i_addr[31:ADDR_W+2], i_addr[1:0],
                                d_addr[31:ADDR_W+2]};

    // ------------------------------------------------------------------
    // Memory command, issued in the grant cycle
    // ------------------------------------------------------------------
    always_comb begin
        m_en    = 1'b0;
        m_we    = 1'b0;
        m_addr  = '0;
        m_wdata = '0;
        if (w_iGnt) begin
            m_en   = 1'b1;
            m_addr = i_addr[ADDR_W+1:2];
        end else if (w_dGnt && !w_dMisaligned) begin
            m_en    = 1'b1;
            m_we    = d_we;
            m_addr  = d_addr[ADDR_W+1:2];
            m_wdata = d_we ? d_wdata : 32'h0;
        end
    end

    // ------------------------------------------------------------------
    // Starvation counter: counts consecutive cycles a fetch waits
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_starveCnt <= '0;
        end else if (i_req && !w_iGnt) begin
            if (r_starveCnt != c_MAX_CNT) begin
                r_starveCnt <= r_starveCnt + 1'b1;
            end
        end else begin
            r_starveCnt <= '0;
        end
    end

    // ------------------------------------------------------------------
    // Response-route FSM: remembers who owns next cycle's read data
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rspState <= RSP_NONE;
        end else begin
            r_rspState <= w_rspNext;
        end
    end

    always_comb begin
        w_rspNext = RSP_NONE;
        if (w_iGnt) begin
            w_rspNext = RSP_FETCH;
        end else if (w_dGnt) begin
            if (w_dMisaligned) begin
                w_rspNext = RSP_ERR;
            end else if (!d_we) begin
                w_rspNext = RSP_LOAD;
            end
        end
    end

    // Outputs are also gated by rst_n. A read granted just before reset
    // therefore never shows up as a response.
    always_comb begin
        i_rvalid = 1'b0;
        i_rdata  = 32'h0;
        d_rvalid = 1'b0;
        d_rdata  = 32'h0;
        d_err    = 1'b0;
        if (rst_n) begin
            case (r_rspState)
                RSP_FETCH: begin
                    i_rvalid = 1'b1;
                    i_rdata  = m_rdata;
                end
                RSP_LOAD: begin
                    d_rvalid = 1'b1;
                    d_rdata  = m_rdata;
                end
                RSP_ERR: begin
                    d_rvalid = 1'b1;
                    d_err    = 1'b1;
                end
                default: begin
                    i_rvalid = 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_mem_arbiter
//  Description : Directed self-checking bench for mem_arbiter. It includes a
//                behavioural synchronous memory. The bench preloads that
//                memory while reset is held.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int ADDR_W   = 10;
    localparam int MAX_WAIT = 3;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              i_req;
    logic [31:0]       i_addr;
    logic              i_gnt;
    logic              i_rvalid;
    logic [31:0]       i_rdata;
    logic              d_req;
    logic              d_we;
    logic [31:0]       d_addr;
    logic [31:0]       d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [31:0]       d_rdata;
    logic              d_err;
    logic              m_en;
    logic              m_we;
    logic [ADDR_W-1:0] m_addr;
    logic [31:0]       m_wdata;
    logic [31:0]       m_rdata;

    int errCnt = 0;
    int chkCnt = 0;

    logic [31:0] mem [0:(1<<ADDR_W)-1];

    mem_arbiter #(.ADDR_W(ADDR_W), .MAX_WAIT(MAX_WAIT)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_req    (i_req),
        .i_addr   (i_addr),
        .i_gnt    (i_gnt),
        .i_rvalid (i_rvalid),
        .i_rdata  (i_rdata),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_gnt    (d_gnt),
        .d_rvalid (d_rvalid),
        .d_rdata  (d_rdata),
        .d_err    (d_err),
        .m_en     (m_en),
        .m_we     (m_we),
        .m_addr   (m_addr),
        .m_wdata  (m_wdata),
        .m_rdata  (m_rdata)
    );

    always #5 clk = ~clk;

    // Synchronous memory; preload words are rewritten every reset cycle
    always @(posedge clk) begin
        if (!rst_n) begin
            mem[0]  <= 32'h2004000a;
            mem[4]  <= 32'h11040003;
            mem[5]  <= 32'h01284820;
            mem[64] <= 32'hCAFEF00D;
        end else if (m_en) begin
            if (m_we) mem[m_addr] <= m_wdata;
            else      m_rdata     <= mem[m_addr];
        end
    end

    task automatic checkVal(input string tag, input logic [31:0] obs,
                            input logic [31:0] exp);
        chkCnt++;
        if (obs !== exp) begin
            errCnt++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs change here
    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n   = 1'b0;
        i_req   = 1'b1;
        i_addr  = 32'h0;
        d_req   = 1'b1;
        d_we    = 1'b0;
        d_addr  = 32'h100;
        d_wdata = 32'h0;

        // Reset: requests present but nothing may be granted
        for (int k = 0; k < 3; k++) begin
            nextCycle();
            #1;
            checkVal("rst_i_gnt",    {31'h0, i_gnt},    32'h0);
            checkVal("rst_d_gnt",    {31'h0, d_gnt},    32'h0);
            checkVal("rst_m_en",     {31'h0, m_en},     32'h0);
            checkVal("rst_m_addr",   {22'h0, m_addr},   32'h0);
            checkVal("rst_rvalids",  {30'h0, i_rvalid, d_rvalid}, 32'h0);
        end

        // First fetch in first cycle out of reset
        nextCycle();
        rst_n = 1'b1; i_req = 1'b1; i_addr = 32'h0; d_req = 1'b0;
        #1;
        checkVal("fetch0_i_gnt",  {31'h0, i_gnt},  32'h1);
        checkVal("fetch0_m_en",   {31'h0, m_en},   32'h1);
        checkVal("fetch0_m_addr", {22'h0, m_addr}, 32'h0);
        nextCycle();
        i_req = 1'b0;
        #1;
        checkVal("fetch0_i_rvalid", {31'h0, i_rvalid}, 32'h1);
        checkVal("fetch0_i_rdata",  i_rdata,           32'h2004000a);

        // Aligned store to top of memory, then load back
        nextCycle();
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'hFFFFFFFC; d_wdata = 32'h12345678;
        #1;
        checkVal("st_d_gnt",   {31'h0, d_gnt},  32'h1);
        checkVal("st_m_we",    {31'h0, m_we},   32'h1);
        checkVal("st_m_addr",  {22'h0, m_addr}, 32'h3FF);
        checkVal("st_m_wdata", m_wdata,         32'h12345678);
        nextCycle();
        d_we = 1'b0;
        #1;
        checkVal("ld_d_gnt",    {31'h0, d_gnt},    32'h1);
        checkVal("ld_m_en",     {31'h0, m_en},     32'h1);
        checkVal("ld_m_we",     {31'h0, m_we},     32'h0);
        checkVal("ld_m_addr",   {22'h0, m_addr},   32'h3FF);
        checkVal("st_no_rvalid", {31'h0, d_rvalid}, 32'h0);
        nextCycle();
        d_req = 1'b0;
        #1;
        checkVal("ld_d_rvalid", {31'h0, d_rvalid}, 32'h1);
        checkVal("ld_d_rdata",  d_rdata,           32'h12345678);

        // Misaligned load: granted, no memory command, error response
        nextCycle();
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h12;
        #1;
        checkVal("mis_ld_d_gnt", {31'h0, d_gnt}, 32'h1);
        checkVal("mis_ld_m_en",  {31'h0, m_en},  32'h0);
        nextCycle();
        d_we = 1'b1; d_addr = 32'h13; d_wdata = 32'hDEADBEEF;
        #1;
        checkVal("mis_ld_d_err",    {31'h0, d_err},    32'h1);
        checkVal("mis_ld_d_rvalid", {31'h0, d_rvalid}, 32'h1);
        checkVal("mis_ld_d_rdata",  d_rdata,           32'h0);
        checkVal("mis_st_d_gnt",    {31'h0, d_gnt},    32'h1);
        checkVal("mis_st_m_en",     {31'h0, m_en},     32'h0);
        nextCycle();
        d_req = 1'b0; d_addr = 32'h100; d_wdata = 32'hA5A5A5A5;
        #1;
        checkVal("mis_st_d_err",    {31'h0, d_err},    32'h1);
        checkVal("mis_st_d_rvalid", {31'h0, d_rvalid}, 32'h1);
        checkVal("idle_m_addr",     {22'h0, m_addr},   32'h0);
        checkVal("idle_m_wdata",    m_wdata,           32'h0);
        checkVal("idle_m_en",       {31'h0, m_en},     32'h0);
        nextCycle();
        #1;
        checkVal("err_pulse_end", {31'h0, d_err}, 32'h0);

        // Load granted, then reset asserted before the response
        nextCycle();
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
        #1;
        checkVal("prerst_d_gnt", {31'h0, d_gnt}, 32'h1);
        nextCycle();
        rst_n = 1'b0; d_req = 1'b0; i_req = 1'b1;
        #1;
        checkVal("inrst_d_rvalid", {31'h0, d_rvalid}, 32'h0);
        checkVal("inrst_d_rdata",  d_rdata,           32'h0);
        checkVal("inrst_i_gnt",    {31'h0, i_gnt},    32'h0);
        checkVal("inrst_m_en",     {31'h0, m_en},     32'h0);
        nextCycle();
        #1;
        checkVal("inrst2_d_rvalid", {31'h0, d_rvalid}, 32'h0);
        nextCycle();
        rst_n = 1'b1; i_req = 1'b0;
        #1;
        checkVal("postrst_rvalids", {30'h0, i_rvalid, d_rvalid}, 32'h0);

        // Alternating fetch 0x10 and load 0x14
        nextCycle();
        i_req = 1'b1; i_addr = 32'h10;
        #1;
        checkVal("alt_f1_i_gnt",  {31'h0, i_gnt},  32'h1);
        checkVal("alt_f1_m_addr", {22'h0, m_addr}, 32'h4);
        nextCycle();
        i_req = 1'b0; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h14;
        #1;
        checkVal("alt_l1_d_gnt",    {31'h0, d_gnt},    32'h1);
        checkVal("alt_l1_m_addr",   {22'h0, m_addr},   32'h5);
        checkVal("alt_f1_i_rvalid", {31'h0, i_rvalid}, 32'h1);
        checkVal("alt_f1_i_rdata",  i_rdata,           32'h11040003);
        checkVal("alt_f1_d_rvalid", {31'h0, d_rvalid}, 32'h0);
        nextCycle();
        d_req = 1'b0; i_req = 1'b1; i_addr = 32'h11;
        #1;
        checkVal("alt_f2_i_gnt",    {31'h0, i_gnt},    32'h1);
        checkVal("alt_f2_m_addr",   {22'h0, m_addr},   32'h4);
        checkVal("alt_l1_d_rvalid", {31'h0, d_rvalid}, 32'h1);
        checkVal("alt_l1_d_rdata",  d_rdata,           32'h01284820);
        checkVal("alt_l1_i_rvalid", {31'h0, i_rvalid}, 32'h0);
        nextCycle();
        i_req = 1'b0; d_req = 1'b1; d_addr = 32'h14;
        #1;
        checkVal("alt_f2_i_rdata", i_rdata,         32'h11040003);
        checkVal("alt_f2_d_err",   {31'h0, d_err},  32'h0);
        nextCycle();
        d_req = 1'b0;
        #1;
        checkVal("alt_l2_d_rdata", d_rdata, 32'h01284820);

        // Both requesting continuously: three data grants then one fetch
        nextCycle();
        i_addr = 32'h0; d_addr = 32'h100; d_we = 1'b0;
        for (int k = 0; k < 8; k++) begin
            nextCycle();
            i_req = 1'b1; d_req = 1'b1;
            #1;
            checkVal($sformatf("starve_i_gnt_%0d", k), {31'h0, i_gnt},
                     (k % 4 == 3) ? 32'h1 : 32'h0);
            checkVal($sformatf("starve_d_gnt_%0d", k), {31'h0, d_gnt},
                     (k % 4 == 3) ? 32'h0 : 32'h1);
            if (k > 0) begin
                if ((k - 1) % 4 == 3) begin
                    checkVal($sformatf("starve_i_rdata_%0d", k), i_rdata, 32'h2004000a);
                end else begin
                    checkVal($sformatf("starve_d_rdata_%0d", k), d_rdata, 32'hCAFEF00D);
                end
            end
        end
        nextCycle();
        i_req = 1'b0; d_req = 1'b0;
        #1;

        $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
        $finish;
    end

endmodule
`default_nettype wire
